// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is held low, driven high, or driven by a shared 8-bit PWM
// waveform whose duty is double-buffered and only changes at a period boundary.
module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [15:0] out,
    output logic       period_start,
    output logic [7:0] duty_active
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_cnt;
    logic [7:0]    pwm_cnt;
    logic [7:0]    shadow_duty;
    logic          tick;
    logic          wrap_event;
    logic          pwm_sig;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;
    logic [15:0]   out_next;

    // 0xFF saturates to a full-period high instead of 255/256
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == 8'hFF) || (cnt < duty);
    endfunction

    assign tick       = (presc_cnt == PRESC_MAX);
    assign wrap_event = tick && (pwm_cnt == 8'hFF);
    assign pwm_sig    = pwm_level(pwm_cnt, shadow_duty);

    assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign out_next = en_out & (~en_pwm | {16{pwm_sig}});

    assign duty_active = shadow_duty;

    // Prescaler and PWM period counter run free, independent of the enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
            pwm_cnt   <= 8'd0;
        end else begin
            if (tick) begin
                presc_cnt <= '0;
                pwm_cnt   <= pwm_cnt + 8'd1;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    // Duty is latched only at the wrap so a period is never truncated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_duty  <= 8'd0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap_event;
            if (wrap_event) begin
                shadow_duty <= pwm_duty_cycle;
            end
        end
    end

    // Registered pin mux
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 16'd0;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: reset, static pin modes, duty extremes, double buffering,
// and a second instance built with PRESCALE=1.
module tb_pwm_peripheral;

    localparam int PRESCALE = 13;
    localparam int PERIOD   = 256 * PRESCALE;
    localparam int PERIOD1  = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  out_lo = 8'hFF;
    logic [7:0]  out_hi = 8'hFF;
    logic [7:0]  pwm_lo = 8'hFF;
    logic [7:0]  pwm_hi = 8'hFF;
    logic [7:0]  duty   = 8'h55;

    logic [15:0] out;
    logic        period_start;
    logic [7:0]  duty_active;
    logic [15:0] out1;
    logic        period_start1;
    logic [7:0]  duty_active1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
        .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
        .pwm_duty_cycle(duty),
        .out(out), .period_start(period_start), .duty_active(duty_active)
    );

    pwm_peripheral #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
        .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
        .pwm_duty_cycle(duty),
        .out(out1), .period_start(period_start1), .duty_active(duty_active1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for the next period_start sample, bounded to two periods
    task automatic wait_ps(output bit found);
        found = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 4; i++) begin
            @(negedge clk);
            if (period_start) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Called while sitting on a period_start sample; samples one full period of out[0]
    // and ends on the next period_start sample.
    task automatic measure_period(input int change_at, input logic [7:0] new_duty,
                                  output int high, output bit ps_ok, output bit shape_ok);
        bit seen_low;
        high = 0; ps_ok = 1'b1; shape_ok = 1'b1; seen_low = 1'b0;
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            if (i == change_at) duty = new_duty;
            if (out[0]) begin
                high++;
                if (seen_low) shape_ok = 1'b0;
            end else begin
                seen_low = 1'b1;
            end
            if (i < PERIOD && period_start) ps_ok = 1'b0;
            if (i == PERIOD && !period_start) ps_ok = 1'b0;
        end
    endtask

    // From a negedge with rst high: release, then the first period must be low with no pulse
    task automatic restart_check(input string tag);
        bit low_ok, ps_ok;
        low_ok = 1'b1; ps_ok = 1'b1;
        rst = 1'b0;
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            if (out[0]) low_ok = 1'b0;
            if (i < PERIOD && period_start) ps_ok = 1'b0;
            if (i == PERIOD && !period_start) ps_ok = 1'b0;
        end
        check({tag, "_first_period_low"}, low_ok, 1);
        check({tag, "_first_ps_timing"}, ps_ok, 1);
    endtask

    initial begin
        int  high;
        bit  found, ps_ok, shape_ok;

        // Reset held with every input nonzero
        repeat (3) @(negedge clk);
        check("rst_out", out, 16'h0000);
        check("rst_period_start", period_start, 0);
        check("rst_duty_active", duty_active, 8'h00);
        check("rst_out_presc1", out1, 16'h0000);

        out_lo = 8'h01; pwm_lo = 8'h01; out_hi = 8'h00; pwm_hi = 8'h00;
        duty = 8'h80;
        restart_check("por");
        check("duty50_active", duty_active, 8'h80);

        measure_period(0, 8'h00, high, ps_ok, shape_ok);
        check("duty50_high", high, 1664);
        check("duty50_ps_interval", ps_ok, 1);
        check("duty50_high_first", shape_ok, 1);

        // Static modes, enables take effect one clk later
        out_lo = 8'h0F; pwm_lo = 8'h00; out_hi = 8'h80; pwm_hi = 8'h00;
        @(negedge clk);
        check("static_800f", out, 16'h800F);
        out_lo = 8'h00;
        @(negedge clk);
        check("static_8000", out, 16'h8000);
        out_lo = 8'h01; pwm_lo = 8'h01; out_hi = 8'h00;

        // Duty 0x00 over two periods
        duty = 8'h00;
        wait_ps(found);
        check("d00_ps_found", found, 1);
        check("d00_active", duty_active, 8'h00);
        for (int p = 0; p < 2; p++) begin
            measure_period(0, 8'h00, high, ps_ok, shape_ok);
            check("d00_high", high, 0);
        end

        // Duty 0xFF over two periods, no low cycle at the wrap
        duty = 8'hFF;
        wait_ps(found);
        check("dff_ps_found", found, 1);
        check("dff_active", duty_active, 8'hFF);
        for (int p = 0; p < 2; p++) begin
            measure_period(0, 8'h00, high, ps_ok, shape_ok);
            check("dff_high", high, PERIOD);
        end

        // Duty 0x01 -> one prescale step high
        duty = 8'h01;
        wait_ps(found);
        check("d01_ps_found", found, 1);
        measure_period(0, 8'h00, high, ps_ok, shape_ok);
        check("d01_high", high, PRESCALE);
        check("d01_high_first", shape_ok, 1);

        // Double buffering: 0xC0 written near pwm_cnt=0x20 waits for the wrap
        duty = 8'h40;
        wait_ps(found);
        check("db_ps_found", found, 1);
        check("db_active_40", duty_active, 8'h40);
        measure_period(32 * PRESCALE, 8'hC0, high, ps_ok, shape_ok);
        check("db_old_high", high, 832);
        check("db_active_c0", duty_active, 8'hC0);
        measure_period(0, 8'h00, high, ps_ok, shape_ok);
        check("db_new_high", high, 2496);
        check("db_ps_interval", ps_ok, 1);

        // PRESCALE=1 instance
        duty = 8'h03;
        found = 1'b0;
        for (int i = 0; i < 3 * PERIOD1; i++) begin
            @(negedge clk);
            if (period_start1 && duty_active1 == 8'h03) begin
                found = 1'b1;
                break;
            end
        end
        check("p1_ps_found", found, 1);
        high = 0; ps_ok = 1'b1;
        for (int i = 1; i <= PERIOD1; i++) begin
            @(negedge clk);
            if (out1[0]) high++;
            if (i < PERIOD1 && period_start1) ps_ok = 1'b0;
            if (i == PERIOD1 && !period_start1) ps_ok = 1'b0;
        end
        check("p1_high", high, 3);
        check("p1_ps_interval", ps_ok, 1);

        // Asynchronous reset mid-period, away from any clock edge
        out_hi = 8'h80;
        repeat (50) @(negedge clk);
        check("pre_rst_out15", out[15], 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", out, 16'h0000);
        check("async_rst_duty_active", duty_active, 8'h00);
        check("async_rst_period_start", period_start, 0);
        out_hi = 8'h00;
        duty = 8'hFF;
        repeat (3) @(negedge clk);
        restart_check("rerst");
        check("rerst_active", duty_active, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Downstream consumer of the SPI register-file outputs: en_reg_out_*, en_reg_pwm_* and pwm_duty_cycle.
- Drives 16 output pins. Each pin is held low, driven constantly high, or driven by a shared 8-bit PWM waveform.
- The PWM rate is set by a clock prescaler.
- Duty-cycle updates are double-buffered and take effect only at a period boundary, so no glitched or truncated pulses appear.

Parameters:
- PRESCALE, 13: clk cycles per PWM counter step; legal range 1..4096. PWM period = 256*PRESCALE clk cycles (≈3 kHz at 10 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM mode select, pins 7..0
- en_reg_pwm_15_8  input  8  PWM mode select, pins 15..8
- pwm_duty_cycle  input  8  requested duty; high time = duty/256 of period, except 0xFF = 100%
- out  output  16  pin drive; out[15:8] maps to the *_15_8 registers
- period_start  output  1  one-cycle pulse marking the first cycle of each PWM period
- duty_active  output  8  currently applied (shadow) duty, for observability

Behaviour:
- Reset:
  - Asserting rst clears everything immediately (asynchronous): prescale counter, pwm_cnt, shadow duty, out, period_start, duty_active all 0.
  - Release is synchronous to clk.
  - Reset mid-period aborts the period. After release the block restarts exactly as after power-up.
- Prescaler:
  - presc_cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick is asserted in the cycle presc_cnt == PRESCALE-1.
  - With PRESCALE=1, tick is asserted every cycle.
- PWM counter:
  - 8-bit pwm_cnt increments on tick and wraps 255 -> 0.
  - wrap_event = tick && pwm_cnt == 255.
- Shadow duty:
  - On wrap_event, shadow_duty <= pwm_duty_cycle.
  - No other writes. Changes to pwm_duty_cycle mid-period are ignored until the next wrap_event.
  - duty_active = shadow_duty.
  - After reset, shadow_duty = 0, so the first period is fully low in PWM mode.
- period_start: registered. It is 1 in the single cycle following wrap_event, i.e. the first cycle with pwm_cnt == 0 of a new period. It is 0 otherwise, including the first period after reset.
- pwm_sig (combinational):
  - shadow_duty == 0xFF -> 1.
  - Otherwise pwm_sig = (pwm_cnt < shadow_duty), an unsigned 8-bit compare.
  - duty 0 -> constant 0.
  - Duty D < 255 gives exactly D*PRESCALE high clk cycles per period, high phase first.
- Pin mux (registered, 1 clk latency), for each i in 0..15, with en_out[i] and en_pwm[i] from the concatenated 16-bit enables:
  - en_out[i] = 0 -> out[i] = 0 (en_pwm[i] is ignored).
  - en_out[i] = 1, en_pwm[i] = 0 -> out[i] = 1.
  - en_out[i] = 1, en_pwm[i] = 1 -> out[i] = pwm_sig.
- Enable timing: enable inputs are not shadowed. A change is reflected on out one clk after the input changes, even mid-period.
- Input domain: all inputs are synchronous to clk (driven by registered outputs of the SPI block). No synchronizers are required.
- Simultaneous events: if pwm_duty_cycle changes in the same cycle as wrap_event, the new value is captured.
- Counters run freely regardless of the enables.

Test Plan:
- Reset values: hold rst=1 with all inputs nonzero -> out=0, period_start=0, duty_active=0. Assert rst mid-period -> out=0 in the same cycle, with no clk edge needed.
- Static modes: en_reg_out_7_0=0x0F, en_reg_pwm_7_0=0x00, en_reg_out_15_8=0x80 -> out=0x800F one clk later. Then en_reg_out_7_0=0x00 -> out[3:0]=0 one clk later.
- 50% duty (PRESCALE=13): pwm_duty_cycle=0x80, en_out[0]=en_pwm[0]=1; wait for a period_start -> duty_active=0x80. out[0] is high for 1664 cycles, then low for 1664; period_start pulses every 3328 cycles.
- Extremes: duty 0x00 -> out[0] constant 0 across 2 full periods. Duty 0xFF -> constant 1 across 2 full periods, with no low cycle at the wrap. Duty 0x01 -> exactly 13 high cycles per period.
- Double buffering: duty 0x40 active; write 0xC0 at pwm_cnt=0x20 -> the current period still gives 832 high cycles, and the next period (after period_start) gives 2496.
- PRESCALE=1 build: duty 0x03 -> period_start every 256 cycles, out[0] high for exactly 3 cycles per period.
